// File: rtl/bcd_ctrl_pkg.sv
// Shared types, encodings and helpers for the BCD counter controller.
package bcd_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      LD_CLR = 2'd2,
      LD_SET = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OP_LOAD = 2'd0,
      OP_UP   = 2'd1,
      OP_DOWN = 2'd2,
      OP_STOP = 2'd3
   } cmd_op_t;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic bcd_valid(input logic [3:0] nibble);
      return nibble <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_counter_ctrl_if.sv
// Command channel of the BCD counter controller: valid/ready handshake plus reject pulse.
interface bcd_counter_ctrl_if
   import bcd_ctrl_pkg::*;
#(
   parameter int DIGITS = 4
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   cmd_op_t               cmd_op;
   logic [4*DIGITS-1:0]   cmd_data;
   logic                  cmd_err;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_data,
      input  cmd_ready,
      input  cmd_err
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_data,
      output cmd_ready,
      output cmd_err
   );
endinterface

// File: rtl/bcd_carry_chain.sv
// Decimal ripple-enable network: a digit counts only when all lower digits sit at their terminal value.
module bcd_carry_chain
   import bcd_ctrl_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic [4*DIGITS-1:0] dig_q,
   input  logic                dig_reverse,
   input  logic                count_en,
   output logic [DIGITS-1:0]   dig_enable,
   output logic                all_terminal
);
   logic [DIGITS-1:0] terminal;
   logic [3:0]        term_value;

   assign term_value = dig_reverse ? BCD_MIN : BCD_MAX;

   // Exact compare means a malformed nibble can never look terminal.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign terminal[gi] = (dig_q[4*gi +: 4] == term_value);
         if (gi == 0) begin : g_lsd
            assign dig_enable[gi] = count_en;
         end else begin : g_upper
            assign dig_enable[gi] = count_en && (&terminal[gi-1:0]);
         end
      end
   endgenerate

   assign all_terminal = &terminal;

endmodule

// File: rtl/bcd_counter_ctrl.sv
// Sequencer for a chain of BCD T-flip-flop digit cells: command FSM, preset load, count enables, wrap.
module bcd_counter_ctrl
   import bcd_ctrl_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter bit WRAP_STOP = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   bcd_counter_ctrl_if.slave   cmd,
   input  logic                tick,
   input  logic [4*DIGITS-1:0] dig_q,
   output logic [DIGITS-1:0]   dig_enable,
   output logic                dig_reverse,
   output logic [4*DIGITS-1:0] dig_set,
   output logic [4*DIGITS-1:0] dig_reset,
   output logic                wrap,
   output logic                busy
);
   state_t              state_reg, state_next;
   logic                reverse_reg, reverse_next;
   logic                resume_q, resume_next;
   logic [4*DIGITS-1:0] load_data_reg, load_data_next;
   logic                wrap_reg, wrap_next;
   logic                err_reg, err_next;

   logic [DIGITS-1:0]   nib_ok;
   logic                data_ok;
   logic                accept;
   logic                count_en;
   logic                all_terminal;
   logic                rollover;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_check
         assign nib_ok[gi] = bcd_valid(cmd.cmd_data[4*gi +: 4]);
      end
   endgenerate

   assign data_ok       = &nib_ok;
   assign cmd.cmd_ready = reset && (state_reg == IDLE || state_reg == RUN);
   assign accept        = cmd.cmd_valid && cmd.cmd_ready;
   // An accepted command (even a rejected LOAD) swallows the tick of that cycle.
   assign count_en      = reset && (state_reg == RUN) && tick && !accept;
   assign rollover      = count_en && all_terminal;

   bcd_carry_chain #(
      .DIGITS (DIGITS)
   ) u_chain (
      .dig_q        (dig_q),
      .dig_reverse  (reverse_reg),
      .count_en     (count_en),
      .dig_enable   (dig_enable),
      .all_terminal (all_terminal)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg     <= IDLE;
         reverse_reg   <= 1'b0;
         resume_q      <= 1'b0;
         load_data_reg <= '0;
         wrap_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         reverse_reg   <= reverse_next;
         resume_q      <= resume_next;
         load_data_reg <= load_data_next;
         wrap_reg      <= wrap_next;
         err_reg       <= err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      reverse_next   = reverse_reg;
      resume_next    = resume_q;
      load_data_next = load_data_reg;
      wrap_next      = rollover;
      err_next       = 1'b0;
      if (accept) begin
         case (cmd.cmd_op)
            OP_UP: begin
               state_next   = RUN;
               reverse_next = 1'b0;
            end
            OP_DOWN: begin
               state_next   = RUN;
               reverse_next = 1'b1;
            end
            OP_STOP: state_next = IDLE;
            OP_LOAD: begin
               if (data_ok) begin
                  state_next     = LD_CLR;
                  resume_next    = (state_reg == RUN);
                  load_data_next = cmd.cmd_data;
               end else begin
                  err_next = 1'b1;
               end
            end
            default: state_next = state_reg;
         endcase
      end else begin
         case (state_reg)
            LD_CLR:  state_next = LD_SET;
            LD_SET:  state_next = resume_q ? RUN : IDLE;
            RUN:     if (rollover && WRAP_STOP) state_next = IDLE;
            default: state_next = state_reg;
         endcase
      end
   end

   // Cells are held cleared for the whole reset; set is masked so both never coincide.
   assign dig_reset   = (!reset || state_reg == LD_CLR) ? '1 : '0;
   assign dig_set     = (reset && state_reg == LD_SET) ? load_data_reg : '0;
   assign dig_reverse = reverse_reg;
   assign wrap        = wrap_reg;
   assign cmd.cmd_err = err_reg;
   assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_bcd_counter_ctrl.sv
// Directed bench: two-digit counter with behavioural BCD cells fed back into the controller.
module tb_bcd_counter_ctrl;
   import bcd_ctrl_pkg::*;

   localparam int DIGITS = 2;

   logic       clk;
   logic       reset;
   logic       tick;
   logic [7:0] dig_q;
   logic [1:0] dig_enable;
   logic       dig_reverse;
   logic [7:0] dig_set;
   logic [7:0] dig_reset;
   logic       wrap;
   logic       busy;

   int tests_run = 0;
   int tests_failed = 0;

   bcd_counter_ctrl_if #(.DIGITS(DIGITS)) cmd_bus ();

   bcd_counter_ctrl #(
      .DIGITS    (DIGITS),
      .WRAP_STOP (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd         (cmd_bus),
      .tick        (tick),
      .dig_q       (dig_q),
      .dig_enable  (dig_enable),
      .dig_reverse (dig_reverse),
      .dig_set     (dig_set),
      .dig_reset   (dig_reset),
      .wrap        (wrap),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Digit cells: clear beats set beats count.
   function automatic logic [7:0] cells_next(input logic [7:0] q, input logic [7:0] rst,
                                             input logic [7:0] set, input logic [1:0] en,
                                             input logic rev);
      logic [7:0] r;
      r = q;
      for (int d = 0; d < 2; d++) begin
         logic [3:0] n;
         n = q[4*d +: 4];
         if (rst[4*d +: 4] != 4'd0)
            n = n & ~rst[4*d +: 4];
         else if (set[4*d +: 4] != 4'd0)
            n = n | set[4*d +: 4];
         else if (en[d])
            n = rev ? ((n == 4'd0) ? 4'd9 : n - 4'd1) : ((n == 4'd9) ? 4'd0 : n + 4'd1);
         r[4*d +: 4] = n;
      end
      return r;
   endfunction

   always @(posedge clk)
      dig_q <= cells_next(dig_q, dig_reset, dig_set, dig_enable, dig_reverse);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
         $display("[TB] check %s: got %0h", tag, obs);
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input cmd_op_t op, input logic [7:0] data);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = op;
      cmd_bus.cmd_data  = data;
      next_cycle();
      cmd_bus.cmd_valid = 1'b0;
   endtask

   initial begin
      reset             = 1'b0;
      tick              = 1'b0;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_op    = OP_STOP;
      cmd_bus.cmd_data  = 8'h00;

      // Reset held for three cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_dig_reset", dig_reset, 8'hFF);
      check("rst_cmd_ready", cmd_bus.cmd_ready, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      next_cycle();
      @(negedge clk);
      check("idle_busy", busy, 1'b0);
      check("idle_dig_reset", dig_reset, 8'h00);
      check("idle_cmd_ready", cmd_bus.cmd_ready, 1'b1);
      check("idle_reverse", dig_reverse, 1'b0);
      check("idle_wrap", wrap, 1'b0);
      check("idle_dig_q", dig_q, 8'h00);
      @(posedge clk);
      #1;

      // Count up 12 ticks from 00; upper digit enabled only on the tick taken at 09
      send_cmd(OP_UP, 8'h00);
      @(negedge clk);
      check("run_no_tick_enable", dig_enable, 2'b00);
      check("run_busy", busy, 1'b1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) begin
         tick = 1'b1;
         @(negedge clk);
         check($sformatf("up_enable_%0d", i), dig_enable, (i == 9) ? 2'b11 : 2'b01);
         check($sformatf("up_wrap_%0d", i), wrap, 1'b0);
         @(posedge clk);
         #1;
      end
      tick = 1'b0;
      @(negedge clk);
      check("up_final_q", dig_q, 8'h12);
      check("up_final_wrap", wrap, 1'b0);
      @(posedge clk);
      #1;

      // LOAD 99 from IDLE, then roll over upward
      send_cmd(OP_STOP, 8'h00);
      send_cmd(OP_LOAD, 8'h99);
      @(negedge clk);
      check("ld99_clr_reset", dig_reset, 8'hFF);
      check("ld99_clr_set", dig_set, 8'h00);
      check("ld99_clr_ready", cmd_bus.cmd_ready, 1'b0);
      check("ld99_clr_busy", busy, 1'b1);
      next_cycle();
      @(negedge clk);
      check("ld99_set_set", dig_set, 8'h99);
      check("ld99_set_reset", dig_reset, 8'h00);
      check("ld99_set_ready", cmd_bus.cmd_ready, 1'b0);
      next_cycle();
      @(negedge clk);
      check("ld99_done_ready", cmd_bus.cmd_ready, 1'b1);
      check("ld99_done_busy", busy, 1'b0);
      check("ld99_done_q", dig_q, 8'h99);
      @(posedge clk);
      #1;
      send_cmd(OP_UP, 8'h00);
      tick = 1'b1;
      @(negedge clk);
      check("roll_up_enable", dig_enable, 2'b11);
      check("roll_up_wrap_before", wrap, 1'b0);
      next_cycle();
      tick = 1'b0;
      @(negedge clk);
      check("roll_up_q", dig_q, 8'h00);
      check("roll_up_wrap", wrap, 1'b1);
      check("roll_up_busy", busy, 1'b0);
      next_cycle();
      @(negedge clk);
      check("roll_up_wrap_clear", wrap, 1'b0);
      @(posedge clk);
      #1;

      // Count down from 00: rollover to 99, then 98
      send_cmd(OP_DOWN, 8'h00);
      tick = 1'b1;
      @(negedge clk);
      check("down_reverse", dig_reverse, 1'b1);
      check("down_roll_enable", dig_enable, 2'b11);
      next_cycle();
      tick = 1'b0;
      @(negedge clk);
      check("down_roll_q", dig_q, 8'h99);
      check("down_roll_wrap", wrap, 1'b1);
      check("down_roll_busy", busy, 1'b0);
      @(posedge clk);
      #1;
      send_cmd(OP_DOWN, 8'h00);
      tick = 1'b1;
      @(negedge clk);
      check("down_enable", dig_enable, 2'b01);
      next_cycle();
      tick = 1'b0;
      @(negedge clk);
      check("down_q98", dig_q, 8'h98);
      check("down_wrap_quiet", wrap, 1'b0);
      @(posedge clk);
      #1;

      // STOP keeps direction
      send_cmd(OP_STOP, 8'h00);
      @(negedge clk);
      check("stop_busy", busy, 1'b0);
      check("stop_reverse", dig_reverse, 1'b1);
      @(posedge clk);
      #1;

      // Malformed LOAD is rejected with no side effects
      send_cmd(OP_LOAD, 8'h3A);
      @(negedge clk);
      check("bad_ld_err", cmd_bus.cmd_err, 1'b1);
      check("bad_ld_set", dig_set, 8'h00);
      check("bad_ld_reset", dig_reset, 8'h00);
      check("bad_ld_busy", busy, 1'b0);
      check("bad_ld_ready", cmd_bus.cmd_ready, 1'b1);
      next_cycle();
      @(negedge clk);
      check("bad_ld_err_clear", cmd_bus.cmd_err, 1'b0);
      check("bad_ld_q", dig_q, 8'h98);
      @(posedge clk);
      #1;

      // LOAD 45 while running up with tick held high
      send_cmd(OP_UP, 8'h00);
      tick              = 1'b1;
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_op    = OP_LOAD;
      cmd_bus.cmd_data  = 8'h45;
      @(negedge clk);
      check("ld45_accept_enable", dig_enable, 2'b00);
      next_cycle();
      cmd_bus.cmd_valid = 1'b0;
      @(negedge clk);
      check("ld45_clr_ready", cmd_bus.cmd_ready, 1'b0);
      check("ld45_clr_reset", dig_reset, 8'hFF);
      check("ld45_clr_enable", dig_enable, 2'b00);
      next_cycle();
      @(negedge clk);
      check("ld45_set_ready", cmd_bus.cmd_ready, 1'b0);
      check("ld45_set_set", dig_set, 8'h45);
      check("ld45_set_enable", dig_enable, 2'b00);
      next_cycle();
      @(negedge clk);
      check("ld45_resume_q", dig_q, 8'h45);
      check("ld45_resume_ready", cmd_bus.cmd_ready, 1'b1);
      check("ld45_resume_enable", dig_enable, 2'b01);
      next_cycle();
      tick = 1'b0;
      @(negedge clk);
      check("ld45_first_count", dig_q, 8'h46);
      check("ld45_busy", busy, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
